regfile_op_sequencer: RTL
=========================

// Module: regfile_op_sequencer
// PURPOSE
//  Multi-cycle controller that drives the register file and ALU: accepts one 18-bit
//  instruction per valid/ready handshake, issues the two register reads, captures the
//  ALU result, then performs a single register-file write. It is the initiator side of
//  the register-file read/write interface and sits between instruction fetch and datapath.
// PARAMETERS
//  DATA_W    18  data width of register file, ALU and immediate
//  ADDR_W    4   register select width (16 registers)
//  IMM_W     6   immediate field width, sign-extended to DATA_W
//  CNT_W     16  width of retired-instruction counter
// PORTS
//  Clock        in   1        clock; all state updates on posedge
//  Clear        in   1        synchronous active-high reset
//  InstrValid   in   1        instruction present on Instr
//  Instr        in   DATA_W   [17:14] op, [13:10] rd, [9:6] rs1, [5:2] rs2 / [5:0] imm
//  InstrReady   out  1        sequencer can accept an instruction
//  ReadSelect1  out  ADDR_W   register file read port 1 select (rs1)
//  ReadSelect2  out  ADDR_W   register file read port 2 select (rs2)
//  ALUControl   out  2        00 ADD, 01 AND, 10 NAND, 11 NOR
//  ALUSrcImm    out  1        1: ALU B operand = Immediate, 0: ReadData2
//  Immediate    out  DATA_W   sign-extended imm field of latched instruction
//  ALUResult    in   DATA_W   ALU output, sampled in EXECUTE
//  WriteSelect  out  ADDR_W   register file write select (rd)
//  WriteData    out  DATA_W   captured ALU result
//  WriteEnable  out  1        one-cycle write strobe
//  Done         out  1        one-cycle pulse with WriteEnable
//  Illegal      out  1        one-cycle pulse on unsupported opcode
//  RetiredCount out  CNT_W    count of completed writes, wraps to 0
// BEHAVIOUR
//  - Clear: state=IDLE; InstrReady=1; all other outputs and internal regs 0. Clear
//    during any state aborts the operation; no write is issued.
//  - Opcodes: 0000 ADD, 0001 AND, 0010 NAND, 0011 NOR (reg-reg, ALUSrcImm=0);
//    0100 ADDI, 0101 ANDI (ALUSrcImm=1, rs2 ignored); all others illegal.
//  - FSM IDLE -> DECODE -> EXECUTE -> WRITEBACK -> IDLE.
//  - IDLE: InstrReady=1. Transfer when InstrValid&InstrReady at posedge: latch Instr,
//    go DECODE. InstrReady=0 in every other state; Instr ignored when not ready.
//  - DECODE (1 cycle): ReadSelect1/2, ALUControl, ALUSrcImm, Immediate driven from latch.
//    Illegal opcode: Illegal=1 for this cycle, next state IDLE, no write, no count.
//  - EXECUTE (1 cycle): selects/control held; ALUResult registered into WriteData at
//    the end of the cycle.
//  - WRITEBACK (1 cycle): WriteEnable=1, Done=1, WriteSelect=rd; RetiredCount+1 at the
//    edge leaving WRITEBACK (2^CNT_W-1 wraps to 0). Next state IDLE.
//  - Latency: transfer edge N -> WriteEnable high in cycle N+3; throughput 1 instr / 4
//    cycles. Next transfer earliest at edge N+4.
//  - ReadSelect/ALUControl/Immediate hold their last values in IDLE; WriteEnable, Done,
//    Illegal are 0 outside their stated cycles.
//  - Immediate = {{(DATA_W-IMM_W){imm[5]}}, imm}; ADDI/ANDI both use signed extension.
//  - rd may equal rs1/rs2 and rd=0 is a normal register; no forwarding or bypass.
// TESTING
//  - Clear held 2 cycles mid-EXECUTE -> InstrReady=1, WriteEnable never asserts,
//    RetiredCount=0.
//  - ADD rd=3 rs1=1 rs2=2, ALUResult=18'h00005 -> ReadSelect1=1, ReadSelect2=2,
//    ALUControl=00 in DECODE; WriteEnable, Done, WriteSelect=3, WriteData=5 at N+3.
//  - ADDI rd=4 rs1=4 imm=6'b111111 -> ALUSrcImm=1, Immediate=18'h3FFFF, write to r4.
//  - Opcode 1111 -> Illegal pulse in DECODE, no WriteEnable, back to IDLE at N+2.
//  - InstrValid held high for 12 cycles with 3 NOR instrs -> exactly 3 transfers at
//    N, N+4, N+8; RetiredCount=3.
//  - Preload RetiredCount to 16'hFFFF via 65535 ops (or force) -> next op wraps to 0.

Source files
------------

// File: rtl/regfile_op_sequencer.sv
// Register-file / ALU operation sequencer.
// Accepts one instruction per valid/ready handshake and walks it through
// DECODE -> EXECUTE -> WRITEBACK, issuing the two reads, capturing the ALU
// result and strobing a single register-file write.
module regfile_op_sequencer #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 4,
  parameter int IMM_W  = 6,
  parameter int CNT_W  = 16
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic              InstrValid,
  input  logic [DATA_W-1:0] Instr,
  output logic              InstrReady,
  output logic [ADDR_W-1:0] ReadSelect1,
  output logic [ADDR_W-1:0] ReadSelect2,
  output logic [1:0]        ALUControl,
  output logic              ALUSrcImm,
  output logic [DATA_W-1:0] Immediate,
  input  logic [DATA_W-1:0] ALUResult,
  output logic [ADDR_W-1:0] WriteSelect,
  output logic [DATA_W-1:0] WriteData,
  output logic              WriteEnable,
  output logic              Done,
  output logic              Illegal,
  output logic [CNT_W-1:0]  RetiredCount
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DECODE    = 2'd1,
    ST_EXECUTE   = 2'd2,
    ST_WRITEBACK = 2'd3
  } state_e;

  // Instruction field positions, counted down from the MSB.
  localparam int OP_MSB  = DATA_W - 1;
  localparam int RD_MSB  = DATA_W - 5;
  localparam int RS1_MSB = RD_MSB - ADDR_W;
  localparam int RS2_MSB = RS1_MSB - ADDR_W;

  // Opcodes 0000..0101 are supported; everything else is illegal.
  function automatic logic op_is_legal(input logic [3:0] op);
    op_is_legal = (op <= 4'b0101);
  endfunction

  // Immediate forms (01xx) take the B operand from the immediate.
  function automatic logic op_uses_imm(input logic [3:0] op);
    op_uses_imm = (op[3:2] == 2'b01);
  endfunction

  // ALU function is the low two opcode bits (ADDI->ADD, ANDI->AND).
  function automatic logic [1:0] op_alu_ctrl(input logic [3:0] op);
    op_alu_ctrl = op[1:0];
  endfunction

  // Both immediate forms sign-extend the low IMM_W bits.
  function automatic logic [DATA_W-1:0] sign_ext(input logic [IMM_W-1:0] imm);
    sign_ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

  state_e              state_q,   state_d;
  logic [3:0]          op_q,      op_d;
  logic [ADDR_W-1:0]   rd_q,      rd_d;
  logic                ready_q,   ready_d;
  logic [ADDR_W-1:0]   rsel1_q,   rsel1_d;
  logic [ADDR_W-1:0]   rsel2_q,   rsel2_d;
  logic [1:0]          aluctl_q,  aluctl_d;
  logic                srcimm_q,  srcimm_d;
  logic [DATA_W-1:0]   imm_q,     imm_d;
  logic [ADDR_W-1:0]   wsel_q,    wsel_d;
  logic [DATA_W-1:0]   wdata_q,   wdata_d;
  logic                we_q,      we_d;
  logic                done_q,    done_d;
  logic                illegal_q, illegal_d;
  logic [CNT_W-1:0]    retired_q, retired_d;

  logic [3:0] instr_op_s;
  assign instr_op_s = Instr[OP_MSB -: 4];

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so that every port comes straight from a flop.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    ready_d   = 1'b0;
    rsel1_d   = rsel1_q;
    rsel2_d   = rsel2_q;
    aluctl_d  = aluctl_q;
    srcimm_d  = srcimm_q;
    imm_d     = imm_q;
    wsel_d    = wsel_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    retired_d = retired_q;
    case (state_q)
      ST_IDLE: begin
        if (InstrValid && ready_q) begin
          op_d      = instr_op_s;
          rd_d      = Instr[RD_MSB -: ADDR_W];
          rsel1_d   = Instr[RS1_MSB -: ADDR_W];
          rsel2_d   = Instr[RS2_MSB -: ADDR_W];
          aluctl_d  = op_alu_ctrl(instr_op_s);
          srcimm_d  = op_uses_imm(instr_op_s);
          imm_d     = sign_ext(Instr[IMM_W-1:0]);
          illegal_d = ~op_is_legal(instr_op_s);
          state_d   = ST_DECODE;
        end else begin
          ready_d   = 1'b1;
        end
      end
      ST_DECODE: begin
        if (op_is_legal(op_q)) begin
          state_d = ST_EXECUTE;
        end else begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end
      ST_EXECUTE: begin
        wdata_d = ALUResult;
        wsel_d  = rd_q;
        we_d    = 1'b1;
        done_d  = 1'b1;
        state_d = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
        ready_d   = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous clear (clear aborts any op).
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q   <= ST_IDLE;
      op_q      <= 4'd0;
      rd_q      <= '0;
      ready_q   <= 1'b1;
      rsel1_q   <= '0;
      rsel2_q   <= '0;
      aluctl_q  <= 2'd0;
      srcimm_q  <= 1'b0;
      imm_q     <= '0;
      wsel_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      ready_q   <= ready_d;
      rsel1_q   <= rsel1_d;
      rsel2_q   <= rsel2_d;
      aluctl_q  <= aluctl_d;
      srcimm_q  <= srcimm_d;
      imm_q     <= imm_d;
      wsel_q    <= wsel_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  assign InstrReady   = ready_q;
  assign ReadSelect1  = rsel1_q;
  assign ReadSelect2  = rsel2_q;
  assign ALUControl   = aluctl_q;
  assign ALUSrcImm    = srcimm_q;
  assign Immediate    = imm_q;
  assign WriteSelect  = wsel_q;
  assign WriteData    = wdata_q;
  assign WriteEnable  = we_q;
  assign Done         = done_q;
  assign Illegal      = illegal_q;
  assign RetiredCount = retired_q;

endmodule
